// File: rtl/video_sync_generator.sv
// video_sync_generator: interlaced 525-line composite sync timing from a 4 MHz clock.
// A half-line position counter (pos, 127 clk) and a half-line counter (hl, 1050
// per frame) are decoded into registered, glitch-free active-low csync/vsync/burst,
// plus field, line_count and a frame_start pulse.
// Optional feature macro: SYNC_BURST_EN (burst generation; otherwise burst = 1).
module video_sync_generator (
  input  logic       clk4mhz,
  input  logic       rst,
  output logic       csync,
  output logic       vsync,
  output logic       burst,
  output logic       field,
  output logic [9:0] line_count,
  output logic       frame_start
);

  localparam logic [6:0]  POS_LAST  = 7'd126;
  localparam logic [10:0] HL_LAST   = 11'd1049;
  localparam logic [10:0] HL_FIELD2 = 11'd525;

  logic [6:0]  pos;
  logic [10:0] hl;

  logic       f2;
  logic [9:0] rel;
  logic       eq_rgn, broad_rgn, norm_rgn, even_hl;
  logic       csync_d, vsync_d;

  // half-line position and half-line index; one frame is 127 * 1050 clocks
  always_ff @(posedge clk4mhz or posedge rst) begin
    if (rst) begin
      pos <= '0;
      hl  <= '0;
    end else if (pos == POS_LAST) begin
      pos <= '0;
      hl  <= (hl == HL_LAST) ? '0 : hl + 11'd1;
    end else begin
      pos <= pos + 7'd1;
    end
  end

  // region decode: both fields share the same layout relative to their first half-line
  always_comb begin
    f2        = (hl >= HL_FIELD2);
    rel       = f2 ? 10'(hl - HL_FIELD2) : hl[9:0];
    eq_rgn    = (rel < 10'd6) || ((rel >= 10'd12) && (rel < 10'd18));
    broad_rgn = (rel >= 10'd6) && (rel < 10'd12);
    norm_rgn  = (rel >= 10'd18);
    even_hl   = ~hl[0];
    csync_d   = ~((eq_rgn    && (pos <= 7'd8))   ||
                  (broad_rgn && (pos <= 7'd107)) ||
                  (norm_rgn  && even_hl && (pos <= 7'd18)));
    vsync_d   = ~broad_rgn;
  end

  // registered outputs reflect the counter state from before the edge (latency 1)
  always_ff @(posedge clk4mhz or posedge rst) begin
    if (rst) begin
      csync       <= 1'b1;
      vsync       <= 1'b1;
      field       <= 1'b0;
      line_count  <= '0;
      frame_start <= 1'b0;
    end else begin
      csync       <= csync_d;
      vsync       <= vsync_d;
      field       <= f2;
      line_count  <= hl[10:1];
      frame_start <= (hl == 11'd0) && (pos == 7'd0);
    end
  end

`ifdef SYNC_BURST_EN
  logic burst_d;

  // burst flag sits just after the horizontal sync on full lines only
  always_comb begin
    burst_d = ~(norm_rgn && even_hl && (pos >= 7'd21) && (pos <= 7'd30));
  end

  // registered burst, same latency as the other outputs
  always_ff @(posedge clk4mhz or posedge rst) begin
    if (rst) burst <= 1'b1;
    else     burst <= burst_d;
  end
`else
  assign burst = 1'b1;
`endif

endmodule

// File: tb/tb_video_sync_generator.sv
// tb_video_sync_generator: directed checks of reset release, broad/equalizing
// pulses, first normal line, mid-frame reset, field change and frame wrap.
module tb_video_sync_generator;

  logic       clk4mhz;
  logic       rst;
  logic       csync, vsync, burst, field, frame_start;
  logic [9:0] line_count;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  video_sync_generator dut (
    .clk4mhz    (clk4mhz),
    .rst        (rst),
    .csync      (csync),
    .vsync      (vsync),
    .burst      (burst),
    .field      (field),
    .line_count (line_count),
    .frame_start(frame_start)
  );

  initial clk4mhz = 1'b0;
  always #5 clk4mhz = ~clk4mhz;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", tag, edge_n, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_csync"}, 32'(csync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_burst"}, 32'(burst), 32'd1);
    chk({tag, "_field"}, 32'(field), 32'd0);
    chk({tag, "_line"},  32'(line_count), 32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
  endtask

  // walk edges up to 'last' (field 1 only), checking each against the hand-stated timing
  task automatic run_chk(input int last);
    int h, k;
    logic ec, ev, eb;
    while (edge_n < last) begin
      @(posedge clk4mhz);
      edge_n++;
      #1;
      h = (edge_n - 1) / 127;
      k = (edge_n - 1) % 127;
      if (h < 6 || (h >= 12 && h < 18)) ec = (k < 9)   ? 1'b0 : 1'b1;
      else if (h < 12)                  ec = (k < 108) ? 1'b0 : 1'b1;
      else                              ec = (h % 2 == 0 && k < 19) ? 1'b0 : 1'b1;
      ev = (h >= 6 && h < 12) ? 1'b0 : 1'b1;
`ifdef SYNC_BURST_EN
      eb = (h >= 18 && h % 2 == 0 && k >= 21 && k <= 30) ? 1'b0 : 1'b1;
`else
      eb = 1'b1;
`endif
      chk("csync", 32'(csync), 32'(ec));
      chk("vsync", 32'(vsync), 32'(ev));
      chk("burst", 32'(burst), 32'(eb));
      chk("frame_start", 32'(frame_start), (edge_n == 1) ? 32'd1 : 32'd0);
      chk("field", 32'(field), 32'd0);
      chk("line_count", 32'(line_count), 32'(h / 2));
    end
  endtask

  task automatic go(input int e);
    while (edge_n < e) begin
      @(posedge clk4mhz);
      edge_n++;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    #23;
    chk_reset_vals("por");
    @(negedge clk4mhz);
    rst    = 1'b0;
    edge_n = 0;

    // first pass, into the broad region
    run_chk(1000);
    chk("mid_vsync_low", 32'(vsync), 32'd0);

    // asynchronous reset 3 ns after edge 1000
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async");
    @(posedge clk4mhz);
    #1;
    chk_reset_vals("held");
    @(negedge clk4mhz);
    rst    = 1'b0;
    edge_n = 0;

    // second pass must repeat the edge-1 sequence, through the first normal lines
    run_chk(2420);

    go(66675);
    chk("pre_field", 32'(field), 32'd0);
    chk("pre_line", 32'(line_count), 32'd262);
    go(66676);
    chk("field2", 32'(field), 32'd1);
    chk("field2_line", 32'(line_count), 32'd262);

    // jump to the end of the frame and check the wrap
    @(negedge clk4mhz);
    force dut.pos = 7'd120;
    force dut.hl  = 11'd1049;
    #1;
    release dut.pos;
    release dut.hl;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk4mhz);
      #1;
      if (i <= 7) begin
        chk("wrap_pre_field", 32'(field), 32'd1);
        chk("wrap_pre_line", 32'(line_count), 32'd524);
        chk("wrap_pre_fs", 32'(frame_start), 32'd0);
      end else if (i == 8) begin
        chk("wrap_field", 32'(field), 32'd0);
        chk("wrap_line", 32'(line_count), 32'd0);
        chk("wrap_fs", 32'(frame_start), 32'd1);
        chk("wrap_csync", 32'(csync), 32'd0);
        chk("wrap_vsync", 32'(vsync), 32'd1);
      end else begin
        chk("wrap_fs_drop", 32'(frame_start), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
